// File: rtl/background_redraw_fsm_pkg.sv
// Shared constants and state encodings for the background redraw path,
// also used by the sprite drawer and other getBackgroundPixel clients.
package background_redraw_fsm_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int COLOR_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } redraw_state_t;

  function automatic logic frame_last(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                      input int w, input int h);
    return (x == X_W'(w - 1)) && (y == Y_W'(h - 1));
  endfunction

endpackage

// File: rtl/background_redraw_fsm_if.sv
// Redraw sequencer bus: control, getBackgroundPixel lookup and VGA adapter write port.
interface background_redraw_fsm_if;
  import background_redraw_fsm_pkg::*;

  logic               start;
  logic               hold;
  logic [X_W-1:0]     bg_x;
  logic [Y_W-1:0]     bg_y;
  logic [COLOR_W-1:0] bg_color;
  logic [X_W-1:0]     vga_x;
  logic [Y_W-1:0]     vga_y;
  logic [COLOR_W-1:0] vga_colour;
  logic               vga_plot;
  logic               busy;
  logic               done;

  modport master (
    input  start, hold, bg_color,
    output bg_x, bg_y, vga_x, vga_y, vga_colour, vga_plot, busy, done
  );

  modport slave (
    output start, hold, bg_color,
    input  bg_x, bg_y, vga_x, vga_y, vga_colour, vga_plot, busy, done
  );
endinterface

// File: rtl/background_redraw_fsm_pixel_delay_line.sv
// Shift register of {valid, x, y} that aligns issued coordinates with the ROM
// colour arriving DEPTH cycles later.
module background_redraw_fsm_pixel_delay_line
  import background_redraw_fsm_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           issue_valid,
  input  logic [X_W-1:0] issue_x,
  input  logic [Y_W-1:0] issue_y,
  output logic           plot_valid,
  output logic [X_W-1:0] plot_x,
  output logic [Y_W-1:0] plot_y,
  output logic           pending
);

  logic [DEPTH-1:0] valid_r;
  logic [X_W-1:0]   x_r [DEPTH];
  logic [Y_W-1:0]   y_r [DEPTH];

  // Stage shift; reset drops every in-flight pixel
  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        x_r[i] <= '0;
        y_r[i] <= '0;
      end
    end else begin
      valid_r[0] <= issue_valid;
      x_r[0]     <= issue_x;
      y_r[0]     <= issue_y;
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        x_r[i]     <= x_r[i-1];
        y_r[i]     <= y_r[i-1];
      end
    end
  end

  // Pixels still upstream of the output stage; the output stage itself plots this cycle
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      pending = pending | valid_r[i];
    end
  end

  assign plot_valid = valid_r[DEPTH-1];
  assign plot_x     = x_r[DEPTH-1];
  assign plot_y     = y_r[DEPTH-1];

endmodule

// File: rtl/background_redraw_fsm.sv
// Full-screen background redraw: raster-scans getBackgroundPixel and replays each
// coordinate, latency-matched, onto the VGA adapter write port.
module background_redraw_fsm
  import background_redraw_fsm_pkg::*;
#(
  parameter int SCREEN_W    = background_redraw_fsm_pkg::SCREEN_W,
  parameter int SCREEN_H    = background_redraw_fsm_pkg::SCREEN_H,
  parameter int ROM_LATENCY = 1
) (
  input  logic                           clock,
  input  logic                           resetn,
  background_redraw_fsm_if.master        bus
);

  redraw_state_t  state_r;
  logic [X_W-1:0] x_r;
  logic [Y_W-1:0] y_r;
  logic           busy_r;
  logic           done_r;

  logic           issue_valid_s;
  logic           row_end_s;
  logic           last_s;
  logic           pending_s;
  logic           plot_valid_s;
  logic [X_W-1:0] plot_x_s;
  logic [Y_W-1:0] plot_y_s;

  // Issue qualification and raster boundary decode
  always_comb begin
    issue_valid_s = (state_r == ST_DRAW) && !bus.hold;
    row_end_s     = (x_r == X_W'(SCREEN_W - 1));
    last_s        = frame_last(x_r, y_r, SCREEN_W, SCREEN_H);
  end

  // Sequencer FSM with raster counters and registered status outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      x_r     <= '0;
      y_r     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state_r <= ST_DRAW;
            busy_r  <= 1'b1;
          end
        end
        ST_DRAW: begin
          if (issue_valid_s) begin
            if (last_s) begin
              state_r <= ST_DRAIN;
              x_r     <= '0;
              y_r     <= '0;
            end else if (row_end_s) begin
              x_r <= '0;
              y_r <= y_r + Y_W'(1);
            end else begin
              x_r <= x_r + X_W'(1);
            end
          end
        end
        // Leave as the final pixel reaches the output stage so done follows it directly
        ST_DRAIN: begin
          if (!pending_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  background_redraw_fsm_pixel_delay_line #(
    .DEPTH(ROM_LATENCY)
  ) u_delay (
    .clock      (clock),
    .resetn     (resetn),
    .issue_valid(issue_valid_s),
    .issue_x    (x_r),
    .issue_y    (y_r),
    .plot_valid (plot_valid_s),
    .plot_x     (plot_x_s),
    .plot_y     (plot_y_s),
    .pending    (pending_s)
  );

  assign bus.bg_x       = x_r;
  assign bus.bg_y       = y_r;
  assign bus.vga_x      = plot_x_s;
  assign bus.vga_y      = plot_y_s;
  assign bus.vga_colour = bus.bg_color;
  assign bus.vga_plot   = plot_valid_s;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_background_redraw_fsm.sv
// Bench for background_redraw_fsm: latency-1 and latency-2 builds run side by side on a
// reduced screen, each against a random ROM and a pixel-index reference model.
module tb_background_redraw_fsm;
  import background_redraw_fsm_pkg::*;

  localparam int W    = 120;
  localparam int H    = 60;
  localparam int N    = W * H;
  localparam int MAXC = 60000;

  logic clock = 1'b0;
  logic resetn_in;
  logic start_in;
  logic hold_in;

  always #5 clock = ~clock;

  logic [COLOR_W-1:0] rom [0:N-1];

  logic [X_W-1:0]     o_bx   [2];
  logic [Y_W-1:0]     o_by   [2];
  logic [X_W-1:0]     o_vx   [2];
  logic [Y_W-1:0]     o_vy   [2];
  logic [COLOR_W-1:0] o_col  [2];
  logic               o_plot [2];
  logic               o_busy [2];
  logic               o_done [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    background_redraw_fsm_if bus();
    int unsigned apipe [0:k];

    // getBackgroundPixel stand-in: registered ROM read, k+1 cycles deep
    always @(posedge clock) begin
      apipe[0] <= int'(bus.bg_y) * W + int'(bus.bg_x);
      for (int i = 1; i <= k; i++) apipe[i] <= apipe[i-1];
    end

    assign bus.bg_color = rom[apipe[k] % N];
    assign bus.start    = start_in;
    assign bus.hold     = hold_in;

    background_redraw_fsm #(
      .SCREEN_W(W), .SCREEN_H(H), .ROM_LATENCY(k + 1)
    ) dut (
      .clock (clock),
      .resetn(resetn_in),
      .bus   (bus.master)
    );

    assign o_bx[k]   = bus.bg_x;
    assign o_by[k]   = bus.bg_y;
    assign o_vx[k]   = bus.vga_x;
    assign o_vy[k]   = bus.vga_y;
    assign o_col[k]  = bus.vga_colour;
    assign o_plot[k] = bus.vga_plot;
    assign o_busy[k] = bus.busy;
    assign o_done[k] = bus.done;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Reference model: per build, the pixel index due next and the plot source of every cycle
  bit drawing   [2];
  int next_pix  [2];
  int done_cyc  [2];
  int plots     [2];
  int done_seen [2];
  int done_at   [2];
  int hist      [2][MAXC];

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s L=%0d cyc=%0d observed=%0h expected=%0h", tag, k + 1, cyc, obs, exp);
    end
  endtask

  task automatic tick(input bit st, input bit hd, input bit rn);
    start_in  = st;
    hold_in   = hd;
    resetn_in = rn;
    for (int k = 0; k < 2; k++) begin
      int lat;
      lat = k + 1;
      hist[k][cyc] = -1;
      if (!rn) begin
        drawing[k]  = 1'b0;
        next_pix[k] = 0;
        done_cyc[k] = -100;
        for (int j = cyc - lat + 1; j <= cyc; j++) if (j >= 0) hist[k][j] = -1;
      end else if (drawing[k] && !hd) begin
        hist[k][cyc] = next_pix[k];
        next_pix[k]++;
        if (next_pix[k] == N) begin
          drawing[k]  = 1'b0;
          done_cyc[k] = cyc + lat + 1;
        end
      end else if (!drawing[k] && cyc > done_cyc[k] && st) begin
        drawing[k]  = 1'b1;
        next_pix[k] = 0;
      end
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
    if (cyc >= MAXC - 1) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        int src;
        src = (cyc - (k + 1) >= 0) ? hist[k][cyc - (k + 1)] : -1;
        chk("bg_x", k, 32'(o_bx[k]), drawing[k] ? next_pix[k] % W : 0);
        chk("bg_y", k, 32'(o_by[k]), drawing[k] ? next_pix[k] / W : 0);
        chk("vga_plot", k, 32'(o_plot[k]), 32'(src >= 0));
        if (src >= 0) begin
          chk("vga_x", k, 32'(o_vx[k]), src % W);
          chk("vga_y", k, 32'(o_vy[k]), src / W);
          chk("vga_colour", k, 32'(o_col[k]), 32'(rom[src]));
        end
        chk("busy", k, 32'(o_busy[k]), 32'(drawing[k] || cyc < done_cyc[k]));
        chk("done", k, 32'(o_done[k]), 32'(cyc == done_cyc[k]));
        if (o_plot[k] === 1'b1) plots[k]++;
        if (o_done[k] === 1'b1) begin
          done_seen[k]++;
          done_at[k] = cyc;
        end
      end
    end
  endtask

  // mode 0: plain; 1: 10-cycle hold at (100,5); 2: random hold + ignored starts; 3: reset at (50,50)
  task automatic run_frame(input int mode);
    int  budget;
    int  hcnt;
    int  start_cyc;
    bit  held;
    bit  st;
    bit  hd;
    bit  rn;
    for (int k = 0; k < 2; k++) begin
      plots[k]     = 0;
      done_seen[k] = 0;
      done_at[k]   = -1;
    end
    start_cyc = cyc;
    tick(1'b1, 1'b0, 1'b1);
    budget = 3 * N;
    hcnt   = 0;
    held   = 1'b0;
    while ((drawing[0] || drawing[1] || cyc <= done_cyc[0] || cyc <= done_cyc[1]) && budget > 0) begin
      st = 1'b0;
      hd = 1'b0;
      rn = 1'b1;
      case (mode)
        1: begin
          if (!held && drawing[0] && next_pix[0] == 5 * W + 100) begin
            held = 1'b1;
            hcnt = 10;
          end
          if (hcnt > 0) begin
            hd = 1'b1;
            hcnt--;
          end
        end
        2: begin
          hd = ($urandom_range(0, 3) == 0);
          st = (cyc == done_cyc[0]) || (drawing[0] && $urandom_range(0, 15) == 0);
        end
        3: rn = !(drawing[0] && next_pix[0] == 50 * W + 50);
        default: ;
      endcase
      tick(st, hd, rn);
      budget--;
    end
    chk("frame_in_budget", 0, 32'(budget > 0), 32'd1);
    if (mode != 3) begin
      for (int k = 0; k < 2; k++) begin
        chk("plot_count", k, plots[k], N);
        chk("done_pulses", k, done_seen[k], 1);
        if (mode != 2) chk("done_cycle", k, done_at[k] - start_cyc, N + k + 2 + (mode == 1 ? 10 : 0));
      end
    end
    repeat (3) tick(1'b0, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) rom[i] = 3'($urandom_range(0, 7));
    for (int k = 0; k < 2; k++) begin
      drawing[k]  = 1'b0;
      next_pix[k] = 0;
      done_cyc[k] = -100;
    end
    start_in  = 1'b0;
    hold_in   = 1'b0;
    resetn_in = 1'b0;
    @(negedge clock);
    tick(1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b1, 1'b1);
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
